// File: rtl/fcpu_axi_rd_arbiter.sv
// rtl/fcpu_axi_rd_arbiter.sv - round-robin two-master AXI4 read arbiter for the MIG port
// One burst in flight at a time; beat count and RID are checked, and any mismatch sets a sticky error.
module fcpu_axi_rd_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic [ID_W-1:0]   m0_arid,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [7:0]        m0_arlen,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [ID_W-1:0]   m0_rid,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ID_W-1:0]   m1_arid,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [7:0]        m1_arlen,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ID_W-1:0]   m1_rid,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ID_W-1:0]   s_arid,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [7:0]        s_arlen,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [ID_W-1:0]   s_rid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [1:0]        grant,
    output logic              err
);

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_rr_last;
    logic [1:0]        r_grant;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_beat_cnt;
    logic              r_err;

    logic w_win1;
    logic w_ar_hs;
    logic w_sel_rready;
    logic w_beat;
    logic w_err_evt;

    // r_rr_last = 1 means M1 was served last, so M0 wins the next tie
    assign w_win1       = m1_arvalid && (!m0_arvalid || !r_rr_last);
    assign w_ar_hs      = (r_state == IDLE) && (m0_arvalid || m1_arvalid);
    assign w_sel_rready = r_grant[1] ? m1_rready : m0_rready;
    assign w_beat       = (r_state == DATA) && s_rvalid && w_sel_rready;
    assign w_err_evt    = (s_rvalid && (r_state != DATA)) ||
                          (w_beat && ((s_rid != r_id) ||
                                      ( s_rlast && (r_beat_cnt != r_len)) ||
                                      (!s_rlast && (r_beat_cnt == r_len))));

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_ar_hs)             w_next = ADDR;
            ADDR:    if (s_arready)           w_next = DATA;
            DATA:    if (w_beat && s_rlast)   w_next = IDLE;
            default:                          w_next = IDLE;
        endcase
    end

    always_comb begin
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                m0_arready = m0_arvalid && !w_win1;
                m1_arready = w_win1;
            end
            ADDR: s_arvalid = 1'b1;
            DATA: begin
                s_rready  = w_sel_rready;
                m0_rvalid = s_rvalid && r_grant[0];
                m1_rvalid = s_rvalid && r_grant[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rr_last  <= 1'b1;
            r_grant    <= 2'b00;
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else if (w_ar_hs) begin
            r_id       <= w_win1 ? m1_arid   : m0_arid;
            r_addr     <= w_win1 ? m1_araddr : m0_araddr;
            r_len      <= w_win1 ? m1_arlen  : m0_arlen;
            r_grant    <= w_win1 ? 2'b10     : 2'b01;
            r_beat_cnt <= '0;
        end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (s_rlast) begin
                r_grant   <= 2'b00;
                r_rr_last <= r_grant[1];
            end
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign s_arid   = r_id;
    assign s_araddr = r_addr;
    assign s_arlen  = r_len;
    assign grant    = r_grant;
    assign err      = r_err;

    assign m0_rdata = s_rdata;
    assign m0_rid   = s_rid;
    assign m0_rresp = s_rresp;
    assign m0_rlast = s_rlast;
    assign m1_rdata = s_rdata;
    assign m1_rid   = s_rid;
    assign m1_rresp = s_rresp;
    assign m1_rlast = s_rlast;

endmodule

// File: tb/tb_fcpu_axi_rd_arbiter.sv
// tb/tb_fcpu_axi_rd_arbiter.sv - directed table-driven bench for fcpu_axi_rd_arbiter
module tb_fcpu_axi_rd_arbiter;

    logic         clk = 1'b0;
    logic         sys_rst_n;
    logic [3:0]   m0_arid, m1_arid, s_arid, s_rid, m0_rid, m1_rid;
    logic [27:0]  m0_araddr, m1_araddr, s_araddr;
    logic [7:0]   m0_arlen, m1_arlen, s_arlen;
    logic         m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [127:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]   m0_rresp, m1_rresp, s_rresp, grant;
    logic         m0_rlast, m1_rlast, s_rlast;
    logic         m0_rvalid, m1_rvalid, s_rvalid, m0_rready, m1_rready, s_rready;
    logic         s_arvalid, s_arready, err;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fcpu_axi_rd_arbiter dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arvalid(m0_arvalid),
        .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rid(m0_rid), .m0_rresp(m0_rresp),
        .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arvalid(m1_arvalid),
        .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rid(m1_rid), .m1_rresp(m1_rresp),
        .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant), .err(err)
    );

    typedef struct {
        logic [1:0]  req;
        logic [3:0]  id0;
        logic [3:0]  id1;
        logic [27:0] a0;
        logic [27:0] a1;
        logic [7:0]  l0;
        logic [7:0]  l1;
        int          dly;
        logic [1:0]  exp_g;
    } rec_t;

    rec_t tbl[8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pat(input logic [3:0] id, input logic [27:0] addr, input int b);
        return {4'h0, id, 28'h0, addr, 32'h0, 32'(b) ^ 32'hA5A5_0000};
    endfunction

    task automatic clear_inputs();
        m0_arvalid = 0; m1_arvalid = 0; m0_arid = 0; m1_arid = 0;
        m0_araddr = 0; m1_araddr = 0; m0_arlen = 0; m1_arlen = 0;
        m0_rready = 1; m1_rready = 1; s_arready = 0;
        s_rvalid = 0; s_rid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0;
    endtask

    task automatic do_reset();
        sys_rst_n = 0;
        clear_inputs();
        tick(); tick();
        sys_rst_n = 1;
        tick();
    endtask

    task automatic ar_phase(input rec_t r);
        logic        w1;
        w1 = r.exp_g[1];
        m0_arid = r.id0; m0_araddr = r.a0; m0_arlen = r.l0; m0_arvalid = r.req[0];
        m1_arid = r.id1; m1_araddr = r.a1; m1_arlen = r.l1; m1_arvalid = r.req[1];
        #1;
        chk("arready0", m0_arready, r.exp_g[0]);
        chk("arready1", m1_arready, r.exp_g[1]);
        chk("s_arvalid_idle", s_arvalid, 0);
        tick();
        m0_arvalid = 1; m1_arvalid = 1;
        #1;
        chk("arready_busy", {m1_arready, m0_arready}, 2'b00);
        m0_arvalid = 0; m1_arvalid = 0;
        m0_araddr = '1; m1_araddr = '1; m0_arid = '1; m1_arid = '1; m0_arlen = '1; m1_arlen = '1;
        #1;
        chk("grant", grant, r.exp_g);
        chk("s_arvalid", s_arvalid, 1);
        chk("s_arid", s_arid, w1 ? r.id1 : r.id0);
        chk("s_araddr", s_araddr, w1 ? r.a1 : r.a0);
        chk("s_arlen", s_arlen, w1 ? r.l1 : r.l0);
        for (int i = 0; i < r.dly; i++) begin
            tick();
            chk("s_arvalid_hold", s_arvalid, 1);
            chk("s_araddr_hold", s_araddr, w1 ? r.a1 : r.a0);
        end
        s_arready = 1;
        tick();
        s_arready = 0;
    endtask

    task automatic data_phase(input logic sel, input logic [3:0] id, input logic [27:0] addr,
                              input logic [7:0] len);
        for (int b = 0; b <= int'(len); b++) begin
            s_rvalid = 1; s_rid = id; s_rdata = pat(id, addr, b); s_rresp = 2'(b);
            s_rlast = (b == int'(len)); m0_rready = 1; m1_rready = 1;
            #1;
            chk("rvalid_own", sel ? m1_rvalid : m0_rvalid, 1);
            chk("rvalid_other", sel ? m0_rvalid : m1_rvalid, 0);
            chk("rdata", sel ? m1_rdata : m0_rdata, pat(id, addr, b));
            chk("rdata_mirror", sel ? m0_rdata : m1_rdata, pat(id, addr, b));
            chk("rid", {m1_rid, m0_rid}, {id, id});
            chk("rresp", {m1_rresp, m0_rresp}, {2'(b), 2'(b)});
            chk("rlast", {m1_rlast, m0_rlast}, {2{b == int'(len)}});
            chk("s_rready", s_rready, 1);
            tick();
        end
        s_rvalid = 0; s_rlast = 0;
        #1;
        chk("grant_idle", grant, 2'b00);
        chk("err_clean", err, 0);
    endtask

    task automatic beat(input logic [3:0] id, input logic [27:0] addr, input int b, input logic last);
        s_rvalid = 1; s_rid = id; s_rdata = pat(id, addr, b); s_rlast = last;
        tick();
        s_rvalid = 0; s_rlast = 0;
        #1;
    endtask

    initial begin
        rec_t r;
        int   nb;
        logic rr;

        tbl[0] = '{2'b01, 4'd3, 4'd0, 28'h100,    28'h0,     8'd3, 8'd0, 0, 2'b01};
        tbl[1] = '{2'b11, 4'd1, 4'd5, 28'h200,    28'h300,   8'd1, 8'd2, 0, 2'b10};
        tbl[2] = '{2'b11, 4'd2, 4'd6, 28'h210,    28'h310,   8'd2, 8'd1, 0, 2'b01};
        tbl[3] = '{2'b11, 4'd3, 4'd7, 28'h220,    28'h320,   8'd0, 8'd3, 1, 2'b10};
        tbl[4] = '{2'b11, 4'd4, 4'd8, 28'h230,    28'h330,   8'd1, 8'd0, 0, 2'b01};
        tbl[5] = '{2'b10, 4'd0, 4'd7, 28'h0,      28'hABCDE0, 8'd0, 8'd0, 5, 2'b10};
        tbl[6] = '{2'b10, 4'd0, 4'd9, 28'h0,      28'h440,   8'd0, 8'd1, 0, 2'b10};
        tbl[7] = '{2'b11, 4'd12, 4'd13, 28'h550,  28'h660,   8'd2, 8'd0, 2, 2'b01};

        sys_rst_n = 0;
        clear_inputs();
        #12;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("rst_err", err, 0);
        tick();
        sys_rst_n = 1;
        tick();

        for (int i = 0; i < 8; i++) begin
            ar_phase(tbl[i]);
            if (tbl[i].exp_g[1]) data_phase(1'b1, tbl[i].id1, tbl[i].a1, tbl[i].l1);
            else                 data_phase(1'b0, tbl[i].id0, tbl[i].a0, tbl[i].l0);
        end

        // backpressure: M0 rready toggles, every beat must still arrive in order
        r = '{2'b01, 4'd2, 4'd0, 28'h4000, 28'h0, 8'd7, 8'd0, 0, 2'b01};
        ar_phase(r);
        nb = 0;
        for (int c = 0; c < 40 && nb < 8; c++) begin
            rr = (c % 2 == 0);
            m0_rready = rr; s_rvalid = 1; s_rid = 4'd2; s_rdata = pat(4'd2, 28'h4000, nb);
            s_rlast = (nb == 7);
            #1;
            chk("bp_s_rready", s_rready, rr);
            chk("bp_rvalid", m0_rvalid, 1);
            chk("bp_rdata", m0_rdata, pat(4'd2, 28'h4000, nb));
            if (rr) nb++;
            tick();
        end
        s_rvalid = 0; s_rlast = 0; m0_rready = 1;
        #1;
        chk("bp_beats", nb, 8);
        chk("bp_err", err, 0);
        chk("bp_grant", grant, 2'b00);

        // early rlast on beat 2 of a len=3 burst
        r = '{2'b01, 4'd4, 4'd0, 28'h500, 28'h0, 8'd3, 8'd0, 0, 2'b01};
        ar_phase(r);
        beat(4'd4, 28'h500, 0, 1'b0);
        chk("early_err0", err, 0);
        beat(4'd4, 28'h500, 1, 1'b1);
        chk("early_err1", err, 1);
        chk("early_idle", grant, 2'b00);
        tick();
        chk("early_sticky", err, 1);
        do_reset();

        // missing rlast: FSM keeps waiting for it
        r = '{2'b10, 4'd0, 4'd6, 28'h0, 28'h600, 8'd0, 8'd1, 0, 2'b10};
        ar_phase(r);
        beat(4'd6, 28'h600, 0, 1'b0);
        chk("miss_err0", err, 0);
        beat(4'd6, 28'h600, 1, 1'b0);
        chk("miss_err1", err, 1);
        chk("miss_wait", grant, 2'b10);
        beat(4'd6, 28'h600, 2, 1'b1);
        chk("miss_idle", grant, 2'b00);
        do_reset();

        // stray R beat in IDLE is stalled and flagged
        s_rvalid = 1;
        #1;
        chk("stray_s_rready", s_rready, 0);
        chk("stray_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        tick();
        s_rvalid = 0;
        #1;
        chk("stray_err", err, 1);
        do_reset();

        // wrong rid mid-burst: flagged, data still forwarded
        r = '{2'b01, 4'd8, 4'd0, 28'h700, 28'h0, 8'd2, 8'd0, 0, 2'b01};
        ar_phase(r);
        beat(4'd8, 28'h700, 0, 1'b0);
        chk("rid_err0", err, 0);
        s_rvalid = 1; s_rid = 4'd9; s_rdata = pat(4'd9, 28'h700, 1); s_rlast = 0;
        #1;
        chk("rid_fwd_valid", m0_rvalid, 1);
        chk("rid_fwd_data", m0_rdata, pat(4'd9, 28'h700, 1));
        tick();
        chk("rid_err1", err, 1);
        beat(4'd8, 28'h700, 2, 1'b1);
        chk("rid_idle", grant, 2'b00);
        chk("rid_sticky", err, 1);

        // async reset during beat 2 of an M1 burst
        r = '{2'b10, 4'd0, 4'd10, 28'h0, 28'h800, 8'd0, 8'd3, 0, 2'b10};
        ar_phase(r);
        beat(4'd10, 28'h800, 0, 1'b0);
        s_rvalid = 1; s_rid = 4'd10; s_rdata = pat(4'd10, 28'h800, 1);
        #1;
        chk("mid_rvalid", m1_rvalid, 1);
        sys_rst_n = 0;
        #1;
        chk("arst_grant", grant, 2'b00);
        chk("arst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("arst_s_rready", s_rready, 0);
        chk("arst_s_arvalid", s_arvalid, 0);
        chk("arst_err", err, 0);
        clear_inputs();
        tick();
        sys_rst_n = 1;
        tick();
        r = '{2'b11, 4'd11, 4'd12, 28'h900, 28'hA00, 8'd0, 8'd0, 0, 2'b01};
        ar_phase(r);
        data_phase(1'b0, 4'd11, 28'h900, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
